lsu_mem_access: RTL and testbench
=================================

# lsu_mem_access

Load/store unit that executes the memory side of a decoded RV32I instruction. It accepts one load or store per request from the execute stage and drives the word-addressed data-memory port with byte enables and lane-replicated store data. It waits for the memory response, then returns extracted, sign- or zero-extended load data together with the destination-register tag. It sits between the execute stage, which supplies the control word's `mem_read`/`mem_write` and funct3, and the data cache/memory.

## Interface
- `MAX_WAIT`, default 255: cycles spent in ACCESS without `mem_resp` before the access is abandoned with an error; legal range 1..65535.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept; high only in IDLE.
- `req_read` in 1: load request, from control word `mem_read`.
- `req_write` in 1: store request, from control word `mem_write`.
- `req_funct3` in 3: load_funct3 / store_funct3 encoding.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, rs2; low byte/half used for sb/sh.
- `req_rd` in 5: destination register tag, passed through.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `resp_rd` out 5: latched `req_rd`.
- `resp_err` out 1: illegal request, misaligned access, or timeout.
- `mem_read` out 1, `mem_write` out 1: memory strobes, registered.
- `mem_address` out 32: word-aligned address, `{addr[31:2],2'b00}`.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_byte_enable` out 4: write mask; 4'b0000 during reads.
- `mem_rdata` in 32, `mem_resp` in 1: memory read data and completion.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE, on `req_valid`:
  - Latch funct3, address, wdata and rd.
  - If exactly one of `req_read`/`req_write` is set, the funct3 is legal and the address passes the alignment check, go to ACCESS.
  - Otherwise go to RESP with err=1 and issue no memory access.
- Neither read nor write set with `req_valid` high: ignored; remain in IDLE with no response.
- Legal funct3 for loads: 000, 001, 010, 100, 101. Legal funct3 for stores: 000, 001, 010.
- Store byte enables: sb `4'b0001 << addr[1:0]`; sh `addr[1] ? 4'b1100 : 4'b0011`; sw `4'b1111`.
- Store data: sb `{4{wdata[7:0]}}`, sh `{2{wdata[15:0]}}`, sw `wdata`.
- Load extraction, using the byte lane selected by `addr[1:0]` or half selected by `addr[1]`:
  - lb sign-extends bit 7 of the byte; lbu zero-extends.
  - lh sign-extends bit 15 of the half; lhu zero-extends.
  - lw returns the full word.
- ACCESS:
  - Hold `mem_read`/`mem_write`, `mem_address`, `mem_wdata` and `mem_byte_enable` stable.
  - Wait counter starts at 0 and increments each cycle.
  - On `mem_resp`: capture extracted `mem_rdata`, go to RESP with err=0.
  - If the counter reaches `MAX_WAIT-1` and `mem_resp` is still low: go to RESP with err=1 and rdata=0.
- RESP: `resp_valid`=1 for exactly one cycle, then IDLE.
- `mem_resp` arriving while in IDLE or RESP is ignored.

## Timing
- Reset values:
  - State IDLE, so `req_ready`=1.
  - `resp_valid`, `resp_err`, `mem_read` and `mem_write` are 0.
  - `resp_rdata`, `resp_rd`, `mem_address`, `mem_wdata` and `mem_byte_enable` are 0.
- Accept on edge E0. Memory strobes are high from E0 to the edge following `mem_resp`.
- `mem_resp` sampled at edge Ek: strobes drop and `resp_valid` is high in the cycle after Ek.
- Minimum latency is 2 cycles, request accept to `resp_valid`, with a 0-wait memory (`mem_resp` in the first ACCESS cycle).
- Rejected request: `resp_valid` in the cycle right after acceptance; memory strobes never assert.
- Throughput: one access per 3 cycles minimum. `req_ready` is low from ACCESS entry until IDLE is re-entered.
- `rst` asserted in any state: at the next edge state=IDLE, strobes=0, `resp_valid`=0, and the in-flight access is dropped with no response.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: lh/lhu/sh with `addr[0]`=1, or lw/sw with `addr[1:0]`≠0, is rejected. Result is RESP with err=1, rdata=0, no memory access.
- Macro undefined: no alignment check, and misaligned accesses are never errors.
  - Half accesses ignore `addr[0]` and use `addr[1]`.
  - Word accesses ignore `addr[1:0]`.

## Test plan
- lw, addr 0x100, memory returns 0xDEADBEEF after 3 wait cycles -> `mem_address`=0x100, `mem_byte_enable`=0000; `resp_rdata`=0xDEADBEEF, `resp_err`=0, `resp_rd` as sent.
- lb addr 0x203 then lbu addr 0x203, `mem_rdata`=0x80FF1234 -> `resp_rdata`=0xFFFFFF80, then 0x00000080.
- sh addr 0x302, wdata 0x0000ABCD -> `mem_write`=1, `mem_byte_enable`=1100, `mem_wdata`=0xABCDABCD; `resp_rdata`=0.
- sw addr 0x401 -> with macro: no strobe, `resp_err`=1 in the cycle after acceptance. Without macro: `mem_address`=0x400, `mem_byte_enable`=1111, `resp_err`=0.
- `MAX_WAIT`=4, `mem_resp` held low -> strobes drop after 4 ACCESS cycles, `resp_err`=1, `resp_rdata`=0; a later `mem_resp` is ignored.
- `rst` pulsed during ACCESS -> `mem_read`=0 and `req_ready`=1 after that edge; no `resp_valid`; next lw completes normally.

Source files
------------

// File: rtl/lsu_mem_access_if.sv
// Request/response and data-memory bundle for the load/store unit.
// slave: the LSU side; master: execute stage plus memory model.
interface lsu_mem_access_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_read;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;

    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic        resp_err;

    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_rdata;
    logic        mem_resp;

    modport slave (
        input  req_valid, req_read, req_write, req_funct3,
        input  req_addr, req_wdata, req_rd,
        input  mem_rdata, mem_resp,
        output req_ready, resp_valid, resp_rdata, resp_rd, resp_err,
        output mem_read, mem_write, mem_address, mem_wdata,
        output mem_byte_enable
    );

    modport master (
        output req_valid, req_read, req_write, req_funct3,
        output req_addr, req_wdata, req_rd,
        output mem_rdata, mem_resp,
        input  req_ready, resp_valid, resp_rdata, resp_rd, resp_err,
        input  mem_read, mem_write, mem_address, mem_wdata,
        input  mem_byte_enable
    );
endinterface

// File: rtl/lsu_mem_access.sv
// RV32I load/store unit: one access per request, IDLE/ACCESS/RESP FSM.
// Ports: clk, rst (sync, active-high), bus (lsu_mem_access_if.slave).
// MAX_WAIT: ACCESS cycles without mem_resp before a timeout error.
// Optional LSU_MISALIGN_TRAP_EN: reject misaligned half/word accesses.
module lsu_mem_access #(
    parameter int MAX_WAIT = 255
) (
    input logic              clk,
    input logic              rst,
    lsu_mem_access_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [15:0] LAST = 16'(MAX_WAIT - 1);

    state_t      state, state_d;
    logic [2:0]  f3;
    logic [1:0]  a_lo;
    logic [15:0] cnt;
    logic        rd_q, wr_q, valid_q, err_q;
    logic [29:0] addr_q;
    logic [31:0] wdata_q, rdata_q;
    logic [3:0]  be_q;
    logic [4:0]  rd_tag;

    logic        f3_ok, misalign, accept, reject, done, timeout;
    logic [3:0]  be_d;
    logic [31:0] wd_d;

    function automatic logic [31:0] load_ext(
        input logic [2:0]  fn,
        input logic [1:0]  a,
        input logic [31:0] d
    );
        logic [7:0]  b;
        logic [15:0] h;
        unique case (a)
            2'd0: b = d[7:0];
            2'd1: b = d[15:8];
            2'd2: b = d[23:16];
            default: b = d[31:24];
        endcase
        h = a[1] ? d[31:16] : d[15:0];
        unique case (fn)
            3'b000:  load_ext = {{24{b[7]}}, b};
            3'b001:  load_ext = {{16{h[15]}}, h};
            3'b100:  load_ext = {24'd0, b};
            3'b101:  load_ext = {16'd0, h};
            default: load_ext = d;
        endcase
    endfunction

    // Request decode: legality, alignment, store lanes.
    always_comb begin
        if (bus.req_read) begin
            f3_ok = (bus.req_funct3 inside
                     {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        end else begin
            f3_ok = (bus.req_funct3 inside {3'b000, 3'b001, 3'b010});
        end
`ifdef LSU_MISALIGN_TRAP_EN
        misalign = (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0]) ||
                   (bus.req_funct3[1:0] == 2'b10 &&
                    bus.req_addr[1:0] != 2'b00);
`else
        misalign = 1'b0;
`endif
        unique case (bus.req_funct3[1:0])
            2'b00: begin
                be_d = 4'b0001 << bus.req_addr[1:0];
                wd_d = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                be_d = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                wd_d = {2{bus.req_wdata[15:0]}};
            end
            default: begin
                be_d = 4'b1111;
                wd_d = bus.req_wdata;
            end
        endcase
    end

    always_comb begin
        state_d = state;
        accept  = 1'b0;
        reject  = 1'b0;
        done    = 1'b0;
        timeout = 1'b0;
        unique case (state)
            IDLE: begin
                // Neither read nor write: not a memory op, ignored.
                if (bus.req_valid && (bus.req_read || bus.req_write)) begin
                    if ((bus.req_read ^ bus.req_write) && f3_ok &&
                        !misalign) begin
                        accept  = 1'b1;
                        state_d = ACCESS;
                    end else begin
                        reject  = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            ACCESS: begin
                if (bus.mem_resp) begin
                    done    = 1'b1;
                    state_d = RESP;
                end else if (cnt == LAST) begin
                    timeout = 1'b1;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            f3      <= '0;
            a_lo    <= '0;
            cnt     <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            rd_tag  <= '0;
        end else begin
            valid_q <= 1'b0;
            if (accept || reject) begin
                f3     <= bus.req_funct3;
                a_lo   <= bus.req_addr[1:0];
                rd_tag <= bus.req_rd;
            end
            if (accept) begin
                rd_q    <= bus.req_read;
                wr_q    <= bus.req_write;
                addr_q  <= bus.req_addr[31:2];
                wdata_q <= bus.req_write ? wd_d : 32'd0;
                be_q    <= bus.req_write ? be_d : 4'd0;
                cnt     <= '0;
            end
            if (reject) begin
                valid_q <= 1'b1;
                err_q   <= 1'b1;
                rdata_q <= '0;
            end
            if (state == ACCESS) begin
                cnt <= cnt + 16'd1;
            end
            if (done || timeout) begin
                rd_q    <= 1'b0;
                wr_q    <= 1'b0;
                valid_q <= 1'b1;
                err_q   <= timeout;
                rdata_q <= (done && rd_q) ?
                           load_ext(f3, a_lo, bus.mem_rdata) : 32'd0;
            end
        end
    end

    assign bus.req_ready       = (state == IDLE);
    assign bus.resp_valid      = valid_q;
    assign bus.resp_rdata      = rdata_q;
    assign bus.resp_rd         = rd_tag;
    assign bus.resp_err        = err_q;
    assign bus.mem_read        = rd_q;
    assign bus.mem_write       = wr_q;
    assign bus.mem_address     = {addr_q, 2'b00};
    assign bus.mem_wdata       = wdata_q;
    assign bus.mem_byte_enable = be_q;
endmodule

// File: tb/tb_lsu_mem_access.sv
// Testbench for lsu_mem_access: vector table plus response scoreboard.
// Built with MAX_WAIT=4 so the timeout path is exercised quickly.
module tb_lsu_mem_access;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_mem_access_if bus ();

    lsu_mem_access #(.MAX_WAIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit          rd;
        bit          wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  tag;
        logic [31:0] mrdata;
        int          wait_c;   // ACCESS cycles before mem_resp; -1 never
        bit          acc;      // expect a memory access
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] e_rdata;
        bit          e_err;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_vec = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.req_valid  = 1'b1;
        bus.req_read   = v.rd;
        bus.req_write  = v.wr;
        bus.req_funct3 = v.f3;
        bus.req_addr   = v.addr;
        bus.req_wdata  = v.wdata;
        bus.req_rd     = v.tag;
    endtask

    task automatic run(input vec_t v);
        int   n;
        int   k;
        int   lat;
        bit   got;
        vec_t e;
        n_vec++;
        chk("ready_before", bus.req_ready, 1);
        drive(v);
        sb.push_back(v);
        @(negedge clk);
        bus.req_valid = 1'b0;
        n = 1;
        k = 0;
        got = 1'b0;
        if (v.acc) begin
            chk("mem_read", bus.mem_read, v.rd);
            chk("mem_write", bus.mem_write, v.wr);
            chk("mem_address", bus.mem_address, v.e_addr);
            chk("byte_enable", bus.mem_byte_enable, v.e_be);
            if (v.wr) chk("mem_wdata", bus.mem_wdata, v.e_wdata);
            chk("ready_busy", bus.req_ready, 0);
        end else begin
            chk("no_strobe", bus.mem_read | bus.mem_write, 0);
        end
        while (n < 30 && !got) begin
            if (bus.resp_valid) begin
                got = 1'b1;
                if (sb.size() == 0) begin
                    chk("unexpected_resp", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("resp_rdata", bus.resp_rdata, e.e_rdata);
                    chk("resp_err", bus.resp_err, e.e_err);
                    chk("resp_rd", bus.resp_rd, e.tag);
                    lat = !e.acc ? 1 : (e.wait_c < 0 ? 5 : e.wait_c + 2);
                    chk("latency", n, lat);
                    chk("strobes_off", bus.mem_read | bus.mem_write, 0);
                end
            end else begin
                if (bus.mem_read | bus.mem_write) begin
                    chk("addr_hold", bus.mem_address, v.e_addr);
                    bus.mem_resp  = (k == v.wait_c);
                    bus.mem_rdata = (k == v.wait_c) ? v.mrdata : $urandom;
                    k++;
                end else begin
                    bus.mem_resp = 1'b0;
                end
                @(negedge clk);
                n++;
            end
        end
        bus.mem_resp = 1'b0;
        if (!got) chk("resp_timeout", 0, 1);
        @(negedge clk);
        chk("one_pulse", bus.resp_valid, 0);
        chk("ready_after", bus.req_ready, 1);
    endtask

    initial begin
        vec_t v;
        bus.req_valid  = 1'b0;
        bus.req_read   = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'b0;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.req_rd     = 5'd0;
        bus.mem_rdata  = 32'h0;
        bus.mem_resp   = 1'b0;

        tbl.push_back('{1, 0, 3'b010, 32'h100, 32'h0, 5'd5, 32'hDEADBEEF,
                        3, 1, 32'h100, 4'h0, 32'h0, 32'hDEADBEEF, 0});
        tbl.push_back('{1, 0, 3'b000, 32'h203, 32'h0, 5'd6, 32'h80FF1234,
                        0, 1, 32'h200, 4'h0, 32'h0, 32'hFFFFFF80, 0});
        tbl.push_back('{1, 0, 3'b100, 32'h203, 32'h0, 5'd7, 32'h80FF1234,
                        1, 1, 32'h200, 4'h0, 32'h0, 32'h00000080, 0});
        tbl.push_back('{0, 1, 3'b001, 32'h302, 32'h0000ABCD, 5'd8, 32'h0,
                        2, 1, 32'h300, 4'hC, 32'hABCDABCD, 32'h0, 0});
`ifdef LSU_MISALIGN_TRAP_EN
        tbl.push_back('{0, 1, 3'b010, 32'h401, 32'h12345678, 5'd9, 32'h0,
                        0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 1});
        tbl.push_back('{1, 0, 3'b001, 32'h201, 32'h0, 5'd13, 32'h00008001,
                        0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 1});
`else
        tbl.push_back('{0, 1, 3'b010, 32'h401, 32'h12345678, 5'd9, 32'h0,
                        0, 1, 32'h400, 4'hF, 32'h12345678, 32'h0, 0});
        tbl.push_back('{1, 0, 3'b001, 32'h201, 32'h0, 5'd13, 32'h00008001,
                        0, 1, 32'h200, 4'h0, 32'h0, 32'hFFFF8001, 0});
`endif
        tbl.push_back('{0, 1, 3'b000, 32'h101, 32'h000000A5, 5'd10, 32'h0,
                        1, 1, 32'h100, 4'h2, 32'hA5A5A5A5, 32'h0, 0});
        tbl.push_back('{1, 0, 3'b001, 32'h202, 32'h0, 5'd11, 32'h80FF1234,
                        0, 1, 32'h200, 4'h0, 32'h0, 32'hFFFF80FF, 0});
        tbl.push_back('{1, 0, 3'b101, 32'h200, 32'h0, 5'd12, 32'h80FF9234,
                        2, 1, 32'h200, 4'h0, 32'h0, 32'h00009234, 0});
        tbl.push_back('{1, 0, 3'b000, 32'h100, 32'h0, 5'd14, 32'h1234567F,
                        0, 1, 32'h100, 4'h0, 32'h0, 32'h0000007F, 0});
        tbl.push_back('{1, 0, 3'b100, 32'h102, 32'h0, 5'd15, 32'h11223344,
                        3, 1, 32'h100, 4'h0, 32'h0, 32'h00000022, 0});
        tbl.push_back('{1, 0, 3'b011, 32'h100, 32'h0, 5'd16, 32'h0,
                        0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 1});
        tbl.push_back('{0, 1, 3'b100, 32'h100, 32'h0, 5'd17, 32'h0,
                        0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 1});
        tbl.push_back('{1, 1, 3'b010, 32'h100, 32'h0, 5'd18, 32'h0,
                        0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 1});
        tbl.push_back('{1, 0, 3'b010, 32'h500, 32'h0, 5'd19, 32'h0,
                        -1, 1, 32'h500, 4'h0, 32'h0, 32'h0, 1});

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", bus.req_ready, 1);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_resp_err", bus.resp_err, 0);
        chk("rst_mem_read", bus.mem_read, 0);
        chk("rst_mem_write", bus.mem_write, 0);
        chk("rst_resp_rdata", bus.resp_rdata, 0);
        chk("rst_resp_rd", bus.resp_rd, 0);
        chk("rst_mem_address", bus.mem_address, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_byte_enable", bus.mem_byte_enable, 0);
        rst = 1'b0;
        @(negedge clk);

        foreach (tbl[i]) run(tbl[i]);

        // Late mem_resp after the timeout is ignored
        n_vec++;
        bus.mem_resp = 1'b1;
        @(negedge clk);
        bus.mem_resp = 1'b0;
        chk("late_resp_valid", bus.resp_valid, 0);
        chk("late_resp_ready", bus.req_ready, 1);

        // Neither read nor write: no response, stays in IDLE
        n_vec++;
        v = tbl[0];
        v.rd = 0;
        v.wr = 0;
        drive(v);
        @(negedge clk);
        bus.req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("nop_resp_valid", bus.resp_valid, 0);
            chk("nop_ready", bus.req_ready, 1);
            chk("nop_strobe", bus.mem_read, 0);
            @(negedge clk);
        end

        // Reset during ACCESS drops the access silently
        n_vec++;
        drive(tbl[0]);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("pre_rst_mem_read", bus.mem_read, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_mem_read", bus.mem_read, 0);
        chk("mid_rst_ready", bus.req_ready, 1);
        chk("mid_rst_resp_valid", bus.resp_valid, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_no_resp", bus.resp_valid, 0);
        end

        run(tbl[0]);
        chk("scoreboard_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
